// File: rtl/reset_seq.sv
// Sequenced reset release: brings NSTAGE downstream domains out of reset in order,
// waiting on each domain's acknowledge, and drops everything back on a lost ack or timeout.
module reset_seq #(
  parameter int NSTAGE  = 4,
  parameter int SW      = 2,
  parameter int DELAY   = 200000,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NSTAGE-1:0] ack,
  output logic [NSTAGE-1:0] rst_out,
  output logic              done,
  output logic              err,
  output logic [SW-1:0]     err_stage
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DLY,
    WAIT_ACK,
    RUN,
    FAULT
  } state_e;

  localparam logic [31:0]   DLY_LAST = 32'(DELAY - 1);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(NSTAGE - 1);

  state_e              state_q;
  logic [31:0]         cnt_q;
  logic [SW-1:0]       idx_q;
  logic [NSTAGE-1:0]   rstOut_q;
  logic                done_q;
  logic                err_q;
  logic [SW-1:0]       errStage_q;
  logic [NSTAGE-1:0]   ackMeta_q;
  logic [NSTAGE-1:0]   ackSync_q;

  logic [NSTAGE-1:0]   checkMask_d;
  logic [NSTAGE-1:0]   lostMask_d;
  logic [SW-1:0]       lostIdx_d;
  logic                lostAny_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackMeta_q <= '0;
      ackSync_q <= '0;
    end else begin
      ackMeta_q <= ack;
      ackSync_q <= ackMeta_q;
    end
  end

  // Stages already acknowledged must stay acknowledged; find the lowest one that dropped.
  always_comb begin
    checkMask_d = '0;
    if (state_q == RUN) begin
      checkMask_d = '1;
    end else if (state_q == WAIT_DLY || state_q == WAIT_ACK) begin
      for (int i = 0; i < NSTAGE; i++) begin
        checkMask_d[i] = (i < int'(idx_q));
      end
    end
    lostMask_d = checkMask_d & ~ackSync_q;
    lostIdx_d  = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (lostMask_d[i]) lostIdx_d = SW'(i);
    end
    lostAny_d = |lostMask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rstOut_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      errStage_q <= '0;
    end else if (!en) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rstOut_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      errStage_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= WAIT_DLY;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
        WAIT_DLY: begin
          if (lostAny_d) begin
            state_q    <= FAULT;
            cnt_q      <= '0;
            rstOut_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b1;
            errStage_q <= lostIdx_d;
          end else if (cnt_q == DLY_LAST) begin
            rstOut_q[idx_q] <= 1'b1;
            cnt_q           <= '0;
            state_q         <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        // A prior-stage loss outranks this stage's ack, which in turn outranks the timeout.
        WAIT_ACK: begin
          if (lostAny_d) begin
            state_q    <= FAULT;
            cnt_q      <= '0;
            rstOut_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b1;
            errStage_q <= lostIdx_d;
          end else if (ackSync_q[idx_q]) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + SW'(1);
              state_q <= WAIT_DLY;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q    <= FAULT;
            cnt_q      <= '0;
            rstOut_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b1;
            errStage_q <= idx_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        RUN: begin
          if (lostAny_d) begin
            state_q    <= FAULT;
            cnt_q      <= '0;
            rstOut_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b1;
            errStage_q <= lostIdx_d;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rst_out   = rstOut_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_stage = errStage_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with NSTAGE=3, DELAY=10, TIMEOUT=20.
module tb_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] ack;
  logic [2:0] rst_out;
  logic       done;
  logic       err;
  logic [1:0] err_stage;
  logic [6:0] obs;

  int checks;
  int errors;

  reset_seq #(
    .NSTAGE (3),
    .SW     (2),
    .DELAY  (10),
    .TIMEOUT(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ack      (ack),
    .rst_out  (rst_out),
    .done     (done),
    .err      (err),
    .err_stage(err_stage)
  );

  assign obs = {rst_out, done, err, err_stage};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one step after the WAIT_DLY entry edge of stage s; returns one step after its ack is taken.
  task automatic releaseStage(input int s, input logic [2:0] prev);
    logic [2:0] exp;
    exp = prev | (3'b001 << s);
    tick(9);
    checks++;
    if (rst_out !== prev) begin
      errors++;
      $display("[TB] FAIL stage%0d_hold: rst_out=%b expected %b", s, rst_out, prev);
    end
    tick(1);
    checks++;
    if (rst_out !== exp) begin
      errors++;
      $display("[TB] FAIL stage%0d_release: rst_out=%b expected %b", s, rst_out, exp);
    end
    tick(1);
    ack[s] = 1'b1;
    tick(2);
    checks++;
    if (obs !== {exp, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL stage%0d_wait_ack: obs=%b expected %b", s, obs, {exp, 4'b0000});
    end
    tick(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b0;
    ack   = 3'b000;
    tick(3);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL reset_state: obs=%b expected %b", obs, 7'b0000000);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: obs=%b expected %b", obs, 7'b0000000);
    end
  endtask

  task automatic test_nominal;
    en = 1'b1;
    tick(1);
    releaseStage(0, 3'b000);
    releaseStage(1, 3'b001);
    releaseStage(2, 3'b011);
    checks++;
    if (obs !== {3'b111, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL nominal_done: obs=%b expected %b", obs, 7'b1111000);
    end
  endtask

  task automatic test_run_loss;
    ack = 3'b110;
    tick(2);
    checks++;
    if (obs !== {3'b111, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL run_loss_sync_delay: obs=%b expected %b", obs, 7'b1111000);
    end
    tick(1);
    checks++;
    if (obs !== {3'b000, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL run_loss_fault: obs=%b expected %b", obs, 7'b0000100);
    end
    tick(2);
    ack = 3'b111;
    tick(5);
    checks++;
    if (obs !== {3'b000, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL run_loss_held: obs=%b expected %b", obs, 7'b0000100);
    end
    en  = 1'b0;
    ack = 3'b000;
    tick(1);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL run_loss_clear: obs=%b expected %b", obs, 7'b0000000);
    end
    tick(3);
  endtask

  task automatic test_timeout;
    en = 1'b1;
    tick(1);
    releaseStage(0, 3'b000);
    tick(10);
    checks++;
    if (rst_out !== 3'b011) begin
      errors++;
      $display("[TB] FAIL timeout_stage1_release: rst_out=%b expected %b", rst_out, 3'b011);
    end
    tick(19);
    checks++;
    if (obs !== {3'b011, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL timeout_before: obs=%b expected %b", obs, 7'b0110000);
    end
    tick(1);
    checks++;
    if (obs !== {3'b000, 1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL timeout_fault: obs=%b expected %b", obs, 7'b0000101);
    end
    tick(5);
    checks++;
    if (obs !== {3'b000, 1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL timeout_held: obs=%b expected %b", obs, 7'b0000101);
    end
    en = 1'b0;
    tick(1);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL timeout_clear: obs=%b expected %b", obs, 7'b0000000);
    end
    ack = 3'b000;
    tick(3);
  endtask

  task automatic test_abort;
    en = 1'b1;
    tick(1);
    releaseStage(0, 3'b000);
    releaseStage(1, 3'b001);
    tick(3);
    en = 1'b0;
    tick(1);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL abort_clear: obs=%b expected %b", obs, 7'b0000000);
    end
    ack = 3'b000;
    tick(3);
    en = 1'b1;
    tick(1);
    tick(9);
    checks++;
    if (rst_out !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_restart_hold: rst_out=%b expected %b", rst_out, 3'b000);
    end
    tick(1);
    checks++;
    if (rst_out !== 3'b001) begin
      errors++;
      $display("[TB] FAIL abort_restart_release: rst_out=%b expected %b", rst_out, 3'b001);
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_ack_timeout_race;
    en = 1'b1;
    tick(1);
    tick(10);
    tick(17);
    ack = 3'b001;
    tick(3);
    checks++;
    if (obs !== {3'b001, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL race_ack_wins: obs=%b expected %b", obs, 7'b0010000);
    end
    tick(9);
    checks++;
    if (rst_out !== 3'b001) begin
      errors++;
      $display("[TB] FAIL race_stage1_hold: rst_out=%b expected %b", rst_out, 3'b001);
    end
    tick(1);
    checks++;
    if (obs !== {3'b011, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL race_stage1_release: obs=%b expected %b", obs, 7'b0110000);
    end
    en  = 1'b0;
    ack = 3'b000;
    tick(3);
  endtask

  task automatic test_async_reset;
    en = 1'b1;
    tick(1);
    tick(10);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("[TB] FAIL async_reset_immediate: obs=%b expected %b", obs, 7'b0000000);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    releaseStage(0, 3'b000);
    releaseStage(1, 3'b001);
    releaseStage(2, 3'b011);
    checks++;
    if (obs !== {3'b111, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset_restart_done: obs=%b expected %b", obs, 7'b1111000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nominal();
    test_run_loss();
    test_timeout();
    test_abort();
    test_ack_timeout_race();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
